// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//   state_t  : fill FSM encoding (IDLE=0, FETCH=1, UPDATE=2)
//   WORD_W   : instruction word width
//   off_w / idx_w / tag_w / blk_w : derived address-field widths
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam int WORD_W = 32;

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines, input int words);
    return addr_w - 2 - $clog2(lines) - $clog2(words);
  endfunction

  // Block address = PC bits above the word offset, up to ADDR_W-1.
  function automatic int blk_w(input int addr_w, input int words);
    return addr_w - 2 - $clog2(words);
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-port and memory-port bundle of the instruction cache.
//   CPU side    : PC, INVALIDATE in; INSTRUCTION, BUSYWAIT out
//   Memory side : MEM_READ, MEM_ADDRESS out; MEM_READDATA, MEM_BUSYWAIT in
//   Counters    : HIT_COUNT, MISS_COUNT out
// Modport slave is the cache; modport master is the CPU/memory environment.
//
// Handshake: BUSYWAIT works as an inverted ready. INSTRUCTION is valid in
// any cycle where BUSYWAIT is 0, and the CPU must hold PC while BUSYWAIT is
// 1. On the memory side MEM_READ is the request; the block on MEM_READDATA
// is taken on the first rising edge with MEM_READ=1 and MEM_BUSYWAIT=0.
interface icache_if import icache_pkg::*; #(
  parameter int ADDR_W = 10,
  parameter int WORDS  = 4,
  parameter int CNT_W  = 16
);
  localparam int BW = blk_w(ADDR_W, WORDS);

  logic [31:0]             PC;
  logic [WORD_W-1:0]       INSTRUCTION;
  logic                    BUSYWAIT;
  logic                    INVALIDATE;
  logic                    MEM_READ;
  logic [BW-1:0]           MEM_ADDRESS;
  logic [WORD_W*WORDS-1:0] MEM_READDATA;
  logic                    MEM_BUSYWAIT;
  logic [CNT_W-1:0]        HIT_COUNT;
  logic [CNT_W-1:0]        MISS_COUNT;

  modport slave (
    input  PC, INVALIDATE, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS, HIT_COUNT, MISS_COUNT
  );

  modport master (
    output PC, INVALIDATE, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS, HIT_COUNT, MISS_COUNT
  );

endinterface

// File: rtl/icache_sat_counter.sv
// Saturating up-counter used for the hit and miss statistics.
//   clk   : clock
//   clr_n : synchronous active-low clear
//   inc   : count up by one this edge (held at all-ones once reached)
//   count : current value
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache between the CPU fetch port and
// a block-wide instruction memory. Hits are combinational from PC; a miss
// stalls the CPU, fetches one block, and replays as a hit.
//   CLK       : clock, all state changes on the rising edge
//   RESET     : synchronous active-low reset
//   bus       : icache_if.slave (fetch port, memory port, counters)
//   dbg_state : current fill FSM state
module icache import icache_pkg::*; #(
  parameter int ADDR_W = 10,
  parameter int LINES  = 8,
  parameter int WORDS  = 4,
  parameter int CNT_W  = 16
) (
  input  logic     CLK,
  input  logic     RESET,
  icache_if.slave  bus,
  output state_t   dbg_state
);

  localparam int OW = off_w(WORDS);
  localparam int IW = idx_w(LINES);
  localparam int TW = tag_w(ADDR_W, LINES, WORDS);
  localparam int BW = blk_w(ADDR_W, WORDS);

  // Address split of the current PC.
  logic [OW-1:0] off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;

  assign off = bus.PC[2 +: OW];
  assign idx = bus.PC[2 + OW +: IW];
  assign tag = bus.PC[2 + OW + IW +: TW];

  // PC bits outside the decoded window carry no meaning for the cache.
  logic unused_pc;
  assign unused_pc = ^{bus.PC[31:ADDR_W], bus.PC[1:0]};

  // Storage.
  logic [LINES-1:0]  valid;
  logic [TW-1:0]     tag_arr  [LINES];
  logic [WORD_W-1:0] data_arr [LINES][WORDS];

  state_t        state, state_nx;
  logic          inv_pend;
  logic [BW-1:0] mem_addr;

  logic          hit;
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic          fill_en;
  logic          hit_inc;
  logic          miss_inc;

  assign hit      = valid[idx] && (tag_arr[idx] == tag);
  // The fill always targets the latched block address, never the live PC.
  assign fill_idx = mem_addr[IW-1:0];
  assign fill_tag = mem_addr[BW-1 -: TW];
  assign fill_en  = RESET && (state == FETCH) && !bus.MEM_BUSYWAIT;
  assign hit_inc  = (state == IDLE) && hit;
  assign miss_inc = (state == IDLE) && !hit;

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!hit) state_nx = FETCH;
      FETCH:   if (!bus.MEM_BUSYWAIT) state_nx = UPDATE;
      UPDATE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state; everything is forced quiet while in reset.
  always_comb begin
    bus.BUSYWAIT    = 1'b0;
    bus.MEM_READ    = 1'b0;
    bus.INSTRUCTION = '0;
    if (RESET) begin
      bus.INSTRUCTION = data_arr[idx][off];
      case (state)
        IDLE:    bus.BUSYWAIT = !hit;
        FETCH: begin
          bus.BUSYWAIT = 1'b1;
          bus.MEM_READ = 1'b1;
        end
        UPDATE:  bus.BUSYWAIT = 1'b1;
        default: bus.BUSYWAIT = 1'b1;
      endcase
    end
  end

  // State register and control state.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state    <= IDLE;
      valid    <= '0;
      mem_addr <= '0;
      inv_pend <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (bus.INVALIDATE) valid <= '0;
          if (!hit) mem_addr <= bus.PC[ADDR_W-1:2+OW];
        end
        FETCH: begin
          if (bus.INVALIDATE) inv_pend <= 1'b1;
          if (!bus.MEM_BUSYWAIT) valid[fill_idx] <= 1'b1;
        end
        UPDATE: begin
          // A deferred invalidate also wipes the line just filled.
          if (inv_pend || bus.INVALIDATE) valid <= '0;
          inv_pend <= 1'b0;
        end
        default: inv_pend <= 1'b0;
      endcase
    end
  end

  // Tag and data arrays need no reset; valid bits qualify them.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_arr[fill_idx] <= fill_tag;
      for (int w = 0; w < WORDS; w++) begin
        data_arr[fill_idx][w] <= bus.MEM_READDATA[WORD_W*w +: WORD_W];
      end
    end
  end

  assign bus.MEM_ADDRESS = mem_addr;
  assign dbg_state       = state;

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (CLK),
    .clr_n (RESET),
    .inc   (hit_inc),
    .count (bus.HIT_COUNT)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (CLK),
    .clr_n (RESET),
    .inc   (miss_inc),
    .count (bus.MISS_COUNT)
  );

endmodule
